axis_pkt_arb2: RTL and testbench

- Two-input, packet-atomic, round-robin AXI-Stream arbiter. It shares the single tap/hash stream datapath between two producers, for example the PS DMA stream and a PL test-pattern source.
- A grant is held from the first beat to the tlast beat, so packets never interleave and per-packet hash/word/packet statistics stay coherent.
- The output has one registered stage, which drives the tap's s_axis interface directly.
- The source of each beat is tagged on m_axis_tuser. Per-source packet counters feed the status registers.

---
 rtl/axis_pkt_arb2.sv | 181 ++++++++++++++++++
 tb/tb_axis_pkt_arb2.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arb2.sv
// Two-input packet-atomic round-robin AXI-Stream arbiter with a single
// registered output stage, source tagging on tuser and per-source packet counters.
module axis_pkt_arb2 #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    input  logic                  s0_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    input  logic                  s1_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    output logic                  busy,
    output logic                  cur_src,
    output logic [CNT_WIDTH-1:0]  pkt_count0,
    output logic [CNT_WIDTH-1:0]  pkt_count1
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic                    cur_src_r;
    logic                    cur_src_nxt_s;
    logic                    last_grant_r;
    logic                    last_grant_nxt_s;

    logic [DATA_WIDTH-1:0]   m_tdata_r;
    logic                    m_tvalid_r;
    logic                    m_tlast_r;
    logic                    m_tuser_r;
    logic [CNT_WIDTH-1:0]    cnt0_r;
    logic [CNT_WIDTH-1:0]    cnt1_r;

    logic                    out_free_s;
    logic                    sel_valid_s;
    logic                    sel_last_s;
    logic [DATA_WIDTH-1:0]   sel_data_s;
    logic                    accept_s;
    logic                    pkt_done_s;

    // Select the granted source's beat and derive the handshake.
    always_comb begin
        out_free_s = !m_tvalid_r || m_axis_tready;
        if (cur_src_r) begin
            sel_valid_s = s1_axis_tvalid;
            sel_last_s  = s1_axis_tlast;
            sel_data_s  = s1_axis_tdata;
        end else begin
            sel_valid_s = s0_axis_tvalid;
            sel_last_s  = s0_axis_tlast;
            sel_data_s  = s0_axis_tdata;
        end
        accept_s   = (state_r == BUSY) && sel_valid_s && out_free_s;
        pkt_done_s = accept_s && sel_last_s;
    end

    // Only the granted source sees ready, and only while the output slot can take a beat.
    always_comb begin
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        if (state_r == BUSY) begin
            if (cur_src_r) begin
                s1_axis_tready = out_free_s;
            end else begin
                s0_axis_tready = out_free_s;
            end
        end else begin
            s0_axis_tready = 1'b0;
            s1_axis_tready = 1'b0;
        end
    end

    // Next-state logic: arbitrate in IDLE, hold the grant until the tlast beat.
    always_comb begin
        state_nxt_s      = state_r;
        cur_src_nxt_s    = cur_src_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (enable && (s0_axis_tvalid || s1_axis_tvalid)) begin
                    state_nxt_s = BUSY;
                    if (s0_axis_tvalid && s1_axis_tvalid) begin
                        cur_src_nxt_s = !last_grant_r;
                    end else if (s1_axis_tvalid) begin
                        cur_src_nxt_s = 1'b1;
                    end else begin
                        cur_src_nxt_s = 1'b0;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (pkt_done_s) begin
                    state_nxt_s      = IDLE;
                    last_grant_nxt_s = cur_src_r;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM and grant registers; last_grant resets to 1 so source 0 wins the first tie.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r      <= IDLE;
            cur_src_r    <= 1'b0;
            last_grant_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            cur_src_r    <= cur_src_nxt_s;
            last_grant_r <= last_grant_nxt_s;
        end
    end

    // Output register: load on acceptance, drain when downstream takes the beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tdata_r  <= {DATA_WIDTH{1'b0}};
            m_tvalid_r <= 1'b0;
            m_tlast_r  <= 1'b0;
            m_tuser_r  <= 1'b0;
        end else if (accept_s) begin
            m_tdata_r  <= sel_data_s;
            m_tvalid_r <= 1'b1;
            m_tlast_r  <= sel_last_s;
            m_tuser_r  <= cur_src_r;
        end else if (m_axis_tready) begin
            m_tvalid_r <= 1'b0;
        end else begin
            m_tvalid_r <= m_tvalid_r;
        end
    end

    // Per-source packet counters, wrapping naturally.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt0_r <= {CNT_WIDTH{1'b0}};
            cnt1_r <= {CNT_WIDTH{1'b0}};
        end else if (pkt_done_s) begin
            if (cur_src_r) begin
                cnt1_r <= cnt1_r + CNT_ONE;
            end else begin
                cnt0_r <= cnt0_r + CNT_ONE;
            end
        end else begin
            cnt0_r <= cnt0_r;
            cnt1_r <= cnt1_r;
        end
    end

    assign m_axis_tdata  = m_tdata_r;
    assign m_axis_tvalid = m_tvalid_r;
    assign m_axis_tlast  = m_tlast_r;
    assign m_axis_tuser  = m_tuser_r;
    assign busy          = (state_r == BUSY);
    assign cur_src       = cur_src_r;
    assign pkt_count0    = cnt0_r;
    assign pkt_count1    = cnt1_r;

endmodule

// File: tb/tb_axis_pkt_arb2.sv
// Directed bench for axis_pkt_arb2: per-source drivers, an expected-beat queue
// filled by the stimulus and a monitor that pops it on every output transfer.
module tb_axis_pkt_arb2;

    logic        aclk;
    logic        aresetn;
    logic        enable;
    logic [31:0] s0_axis_tdata;
    logic        s0_axis_tvalid;
    logic        s0_axis_tready;
    logic        s0_axis_tlast;
    logic [31:0] s1_axis_tdata;
    logic        s1_axis_tvalid;
    logic        s1_axis_tready;
    logic        s1_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        busy;
    logic        cur_src;
    logic [31:0] pkt_count0;
    logic [31:0] pkt_count1;

    typedef struct {
        logic [31:0] data;
        logic        last;
    } beat_t;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic        user;
    } exp_t;

    beat_t q0[$];
    beat_t q1[$];
    exp_t  sbq[$];
    int    out_cyc[$];
    int    cyc;
    int    checks;
    int    errors;

    axis_pkt_arb2 #(.DATA_WIDTH(32), .CNT_WIDTH(32)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .enable         (enable),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s0_axis_tlast  (s0_axis_tlast),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .s1_axis_tlast  (s1_axis_tlast),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .busy           (busy),
        .cur_src        (cur_src),
        .pkt_count0     (pkt_count0),
        .pkt_count1     (pkt_count1)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic send_pkt(input bit src, input logic [31:0] base, input int n);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + 32'(i);
            b.last = (i == n - 1);
            if (src) q1.push_back(b);
            else     q0.push_back(b);
        end
    endtask

    task automatic expect_pkt(input bit src, input logic [31:0] base, input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = base + 32'(i);
            e.last = (i == n - 1);
            e.user = src;
            sbq.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 300; i++) begin
            @(negedge aclk);
            if (sbq.size() == 0 && q0.size() == 0 && q1.size() == 0) break;
        end
        check(name, 64'(sbq.size()), 64'd0);
        @(negedge aclk);
        @(negedge aclk);
    endtask

    task automatic wait_mvalid(input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (m_axis_tvalid) break;
        end
        check(name, 64'(m_axis_tvalid), 64'd1);
    endtask

    // Source 0 driver: retire the presented beat on handshake, then present the next one.
    initial begin
        s0_axis_tvalid = 1'b0;
        s0_axis_tdata  = 32'd0;
        s0_axis_tlast  = 1'b0;
        forever begin
            @(posedge aclk);
            if (s0_axis_tvalid && s0_axis_tready && q0.size() > 0) void'(q0.pop_front());
            #1;
            if (q0.size() > 0) begin
                s0_axis_tvalid = 1'b1;
                s0_axis_tdata  = q0[0].data;
                s0_axis_tlast  = q0[0].last;
            end else begin
                s0_axis_tvalid = 1'b0;
                s0_axis_tdata  = 32'd0;
                s0_axis_tlast  = 1'b0;
            end
        end
    end

    // Source 1 driver.
    initial begin
        s1_axis_tvalid = 1'b0;
        s1_axis_tdata  = 32'd0;
        s1_axis_tlast  = 1'b0;
        forever begin
            @(posedge aclk);
            if (s1_axis_tvalid && s1_axis_tready && q1.size() > 0) void'(q1.pop_front());
            #1;
            if (q1.size() > 0) begin
                s1_axis_tvalid = 1'b1;
                s1_axis_tdata  = q1[0].data;
                s1_axis_tlast  = q1[0].last;
            end else begin
                s1_axis_tvalid = 1'b0;
                s1_axis_tdata  = 32'd0;
                s1_axis_tlast  = 1'b0;
            end
        end
    end

    // Monitor: every output transfer is compared against the head of the expected queue.
    always @(negedge aclk) begin
        if (aresetn && m_axis_tvalid && m_axis_tready) begin
            out_cyc.push_back(cyc);
            if (sbq.size() == 0) begin
                check("unexpected_beat", {31'd0, m_axis_tuser, m_axis_tdata}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check("out_beat", {30'd0, m_axis_tuser, m_axis_tlast, m_axis_tdata},
                      {30'd0, e.user, e.last, e.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        aresetn       = 1'b0;
        enable        = 1'b1;
        m_axis_tready = 1'b1;
        #12;
        check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rst_tready", {62'd0, s0_axis_tready, s1_axis_tready}, 64'd0);
        check("rst_busy", {62'd0, busy, cur_src}, 64'd0);
        check("rst_out", {31'd0, m_axis_tlast, m_axis_tuser, m_axis_tdata}, 64'd0);
        check("rst_cnt", {pkt_count1, pkt_count0}, 64'd0);
        step();
        aresetn = 1'b1;
        step();

        // Both sources contend with 2-beat packets: expect 0,1,0,1 per packet.
        send_pkt(1'b0, 32'hB0, 2);
        send_pkt(1'b0, 32'hC0, 2);
        send_pkt(1'b1, 32'hD0, 2);
        send_pkt(1'b1, 32'hE0, 2);
        expect_pkt(1'b0, 32'hB0, 2);
        expect_pkt(1'b1, 32'hD0, 2);
        expect_pkt(1'b0, 32'hC0, 2);
        expect_pkt(1'b1, 32'hE0, 2);
        wait_drain("rr_drain");
        check("rr_cnt0", 64'(pkt_count0), 64'd2);
        check("rr_cnt1", 64'(pkt_count1), 64'd2);

        // Source 0 alone, 4 beats back to back.
        out_cyc.delete();
        send_pkt(1'b0, 32'hA0, 4);
        expect_pkt(1'b0, 32'hA0, 4);
        wait_drain("s0_drain");
        check("s0_nbeats", 64'(out_cyc.size()), 64'd4);
        for (int i = 1; i < out_cyc.size(); i++) check("s0_consecutive", 64'(out_cyc[i] - out_cyc[i-1]), 64'd1);
        check("s0_cnt0", 64'(pkt_count0), 64'd3);
        check("s0_cnt1", 64'(pkt_count1), 64'd2);

        // Backpressure: first beat of a source 1 packet must hold for 5 cycles.
        m_axis_tready = 1'b0;
        send_pkt(1'b1, 32'hF0, 3);
        expect_pkt(1'b1, 32'hF0, 3);
        wait_mvalid("stall_seen");
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", 64'(m_axis_tvalid), 64'd1);
            check("stall_data", 64'(m_axis_tdata), 64'hF0);
            check("stall_s1_ready", 64'(s1_axis_tready), 64'd0);
            @(negedge aclk);
        end
        step();
        m_axis_tready = 1'b1;
        wait_drain("stall_drain");
        check("stall_cnt1", 64'(pkt_count1), 64'd3);

        // Enable drops mid-packet: packet completes, source 1 waits for re-enable.
        send_pkt(1'b0, 32'h60, 4);
        send_pkt(1'b1, 32'h70, 2);
        expect_pkt(1'b0, 32'h60, 4);
        expect_pkt(1'b1, 32'h70, 2);
        wait_mvalid("en_seen");
        step();
        enable = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge aclk);
            if (sbq.size() <= 2) break;
        end
        check("en_pkt_done", 64'(sbq.size()), 64'd2);
        @(negedge aclk);
        @(negedge aclk);
        for (int i = 0; i < 4; i++) begin
            check("en_off_idle", {61'd0, busy, m_axis_tvalid, s1_axis_tready}, 64'd0);
            @(negedge aclk);
        end
        step();
        enable = 1'b1;
        wait_drain("en_drain");
        check("en_cnts", {pkt_count1, pkt_count0}, {32'd4, 32'd4});

        // Single-beat packets from source 0: one beat every other cycle.
        out_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send_pkt(1'b0, 32'h50 + 32'(i), 1);
            expect_pkt(1'b0, 32'h50 + 32'(i), 1);
        end
        wait_drain("sb_drain");
        check("sb_nbeats", 64'(out_cyc.size()), 64'd4);
        for (int i = 1; i < out_cyc.size(); i++) check("sb_spacing", 64'(out_cyc[i] - out_cyc[i-1]), 64'd2);
        check("sb_cnt0", 64'(pkt_count0), 64'd8);

        // Reset mid-packet clears everything at once.
        send_pkt(1'b0, 32'h90, 4);
        expect_pkt(1'b0, 32'h90, 4);
        wait_mvalid("rst_mid_seen");
        #2;
        aresetn = 1'b0;
        q0.delete();
        q1.delete();
        sbq.delete();
        #1;
        check("rstm_tvalid", 64'(m_axis_tvalid), 64'd0);
        check("rstm_tready", {62'd0, s0_axis_tready, s1_axis_tready}, 64'd0);
        check("rstm_busy", 64'(busy), 64'd0);
        check("rstm_cnt", {pkt_count1, pkt_count0}, 64'd0);
        step();
        step();
        aresetn = 1'b1;
        step();
        send_pkt(1'b0, 32'h11, 1);
        send_pkt(1'b1, 32'h22, 1);
        expect_pkt(1'b0, 32'h11, 1);
        expect_pkt(1'b1, 32'h22, 1);
        wait_drain("rstm_tie_drain");
        check("rstm_tie_cnts", {pkt_count1, pkt_count0}, {32'd1, 32'd1});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
